fetch_stage: RTL and testbench

Instruction fetch stage directly upstream of `controller`. Owns the PC, issues single-outstanding requests on the instruction-memory port, and presents one registered instruction with `inst_valid_o` until the controller retires it or redirects. Redirects come from `target_valid_i`/`target_addr_i`, which carry jump, branch, ecall and illegal-instruction targets muxed outside this block, including exception vectors 4 and 8.

---
 rtl/riscv_defines.sv | 14 +
 rtl/fetch_stage.sv | 122 ++++++++++++
 tb/tb_fetch_stage.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared widths, NOP encoding and fetch FSM state type
package riscv_defines;

    localparam int          RISCV_ADDR_WIDTH = 32;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - single-outstanding instruction fetch with registered hand-off to the controller
module fetch_stage
    import riscv_defines::*;
#(
    parameter logic [RISCV_ADDR_WIDTH-1:0] BOOT_ADDR = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fetch_en_i,
    output logic                        instr_req_o,
    output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o,
    input  logic                        instr_gnt_i,
    input  logic                        instr_rvalid_i,
    input  logic [31:0]                 instr_rdata_i,
    output logic                        inst_valid_o,
    output logic [31:0]                 instr_o,
    output logic [RISCV_ADDR_WIDTH-1:0] pc_o,
    input  logic                        retire_i,
    input  logic                        target_valid_i,
    input  logic [RISCV_ADDR_WIDTH-1:0] target_addr_i
);

    localparam logic [RISCV_ADDR_WIDTH-1:0] WORD_MASK = {{(RISCV_ADDR_WIDTH-2){1'b1}}, 2'b00};

    fetch_state_e                  state_q;
    logic [RISCV_ADDR_WIDTH-1:0]   pc_q;
    logic [31:0]                   instr_q;
    logic                          kill_q;
    logic                          pend_q;
    logic [RISCV_ADDR_WIDTH-1:0]   pend_addr_q;
    logic                          req_q;
    logic                          valid_q;
    logic [RISCV_ADDR_WIDTH-1:0]   target_aligned;

    assign target_aligned = target_addr_i & WORD_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH_IDLE;
            pc_q        <= BOOT_ADDR;
            instr_q     <= NOP_INST;
            kill_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    if (target_valid_i) begin
                        pc_q <= target_aligned;
                    end
                    if (fetch_en_i) begin
                        state_q <= FETCH_REQ;
                        req_q   <= 1'b1;
                    end
                end

                // pc_q doubles as the bus address, so redirects are parked until gnt
                FETCH_REQ: begin
                    if (instr_gnt_i) begin
                        state_q <= FETCH_WAIT;
                        req_q   <= 1'b0;
                        if (target_valid_i) begin
                            kill_q      <= 1'b1;
                            pend_q      <= 1'b1;
                            pend_addr_q <= target_aligned;
                        end else if (pend_q) begin
                            kill_q <= 1'b1;
                        end
                    end else if (target_valid_i) begin
                        pend_q      <= 1'b1;
                        pend_addr_q <= target_aligned;
                    end
                end

                FETCH_WAIT: begin
                    if (instr_rvalid_i) begin
                        if (target_valid_i || kill_q) begin
                            pc_q    <= target_valid_i ? target_aligned : pend_addr_q;
                            kill_q  <= 1'b0;
                            pend_q  <= 1'b0;
                            state_q <= fetch_en_i ? FETCH_REQ : FETCH_IDLE;
                            req_q   <= fetch_en_i;
                        end else begin
                            instr_q <= instr_rdata_i;
                            state_q <= FETCH_HOLD;
                            valid_q <= 1'b1;
                        end
                    end else if (target_valid_i) begin
                        kill_q      <= 1'b1;
                        pend_q      <= 1'b1;
                        pend_addr_q <= target_aligned;
                    end
                end

                // Target has priority: ecall and taken branches raise retire alongside it
                FETCH_HOLD: begin
                    if (target_valid_i || retire_i) begin
                        pc_q    <= target_valid_i ? target_aligned : pc_q + RISCV_ADDR_WIDTH'(4);
                        valid_q <= 1'b0;
                        state_q <= fetch_en_i ? FETCH_REQ : FETCH_IDLE;
                        req_q   <= fetch_en_i;
                    end
                end

                default: begin
                    state_q <= FETCH_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign instr_req_o  = req_q;
    assign instr_addr_o = pc_q;
    assign inst_valid_o = valid_q;
    assign instr_o      = instr_q;
    assign pc_o         = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        fetch_en_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        inst_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        retire_i;
    logic        target_valid_i;
    logic [31:0] target_addr_i;

    int checks   = 0;
    int failures = 0;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en_i    (fetch_en_i),
        .instr_req_o   (instr_req_o),
        .instr_addr_o  (instr_addr_o),
        .instr_gnt_i   (instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i (instr_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .retire_i      (retire_i),
        .target_valid_i(target_valid_i),
        .target_addr_i (target_addr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request already granted-pending in REQ: grant now, return data next cycle
    task automatic complete_fetch(input logic [31:0] data);
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = data;
        tick();
        instr_rvalid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_en_i = 1'b1; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
        instr_rdata_i = '0; retire_i = 1'b0; target_valid_i = 1'b0; target_addr_i = '0;
        tick(); tick();
        checks++; if (instr_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", instr_req_o); end
        checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid_o); end
        checks++; if (instr_o !== 32'h0000_0013) begin failures++; $display("FAIL reset_instr got=%h exp=00000013", instr_o); end
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_o); end
        rst_n = 1'b1;
        tick();
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin failures++; $display("FAIL boot_req got=%b/%h exp=1/00000000", instr_req_o, instr_addr_o); end
        instr_gnt_i = 1'b1;
        tick();
        checks++; if (instr_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin failures++; $display("FAIL boot_wait got req=%b valid=%b exp 0/0", instr_req_o, inst_valid_o); end
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0050_0093;
        tick();
        instr_rvalid_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'h0050_0093) begin failures++; $display("FAIL boot_hold got v=%b pc=%h i=%h exp 1/00000000/00500093", inst_valid_o, pc_o, instr_o); end
    endtask

    task automatic test_retire_stream();
        for (int k = 1; k <= 4; k++) begin
            retire_i = 1'b1;
            tick();
            retire_i = 1'b0;
            checks++; if (inst_valid_o !== 1'b0 || instr_req_o !== 1'b1 || instr_addr_o !== 32'(4 * k)) begin failures++; $display("FAIL stream_req%0d got v=%b r=%b a=%h exp 0/1/%h", k, inst_valid_o, instr_req_o, instr_addr_o, 32'(4 * k)); end
            complete_fetch(32'hA000_0000 | 32'(k));
            checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'(4 * k) || instr_o !== (32'hA000_0000 | 32'(k))) begin failures++; $display("FAIL stream_hold%0d got v=%b pc=%h i=%h", k, inst_valid_o, pc_o, instr_o); end
        end
    endtask

    task automatic test_retire_and_target();
        retire_i = 1'b1; target_valid_i = 1'b1; target_addr_i = 32'h4;
        tick();
        retire_i = 1'b0; target_valid_i = 1'b0;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h4 || inst_valid_o !== 1'b0) begin failures++; $display("FAIL simul_target got r=%b a=%h v=%b exp 1/00000004/0", instr_req_o, instr_addr_o, inst_valid_o); end
        complete_fetch(32'h0000_0073);
        checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h4 || instr_o !== 32'h0000_0073) begin failures++; $display("FAIL simul_hold got v=%b pc=%h i=%h", inst_valid_o, pc_o, instr_o); end
    endtask

    task automatic test_redirect_wait();
        retire_i = 1'b1;
        tick();
        retire_i = 1'b0;
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0; target_valid_i = 1'b1; target_addr_i = 32'h103;
        tick();
        target_valid_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hDEAD_BEEF;
        tick();
        instr_rvalid_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b0 || instr_req_o !== 1'b1 || instr_addr_o !== 32'h100) begin failures++; $display("FAIL wait_redirect got v=%b r=%b a=%h exp 0/1/00000100", inst_valid_o, instr_req_o, instr_addr_o); end
        checks++; if (instr_o !== 32'h0000_0073) begin failures++; $display("FAIL wait_drop got instr=%h exp=00000073", instr_o); end
        complete_fetch(32'h1111_1111);
        checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== 32'h1111_1111) begin failures++; $display("FAIL wait_refetch got v=%b pc=%h i=%h", inst_valid_o, pc_o, instr_o); end
    endtask

    task automatic test_gnt_stall();
        retire_i = 1'b1;
        tick();
        retire_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            target_valid_i = (c == 0);
            target_addr_i  = 32'h200;
            tick();
            checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h104) begin failures++; $display("FAIL stall_addr%0d got r=%b a=%h exp 1/00000104", c, instr_req_o, instr_addr_o); end
        end
        target_valid_i = 1'b0;
        complete_fetch(32'h2222_2222);
        checks++; if (inst_valid_o !== 1'b0 || instr_req_o !== 1'b1 || instr_addr_o !== 32'h200) begin failures++; $display("FAIL stall_kill got v=%b r=%b a=%h exp 0/1/00000200", inst_valid_o, instr_req_o, instr_addr_o); end
        complete_fetch(32'h3333_3333);
        checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h200 || instr_o !== 32'h3333_3333) begin failures++; $display("FAIL stall_target got v=%b pc=%h i=%h", inst_valid_o, pc_o, instr_o); end
    endtask

    task automatic test_wrap();
        target_valid_i = 1'b1; target_addr_i = 32'hFFFF_FFFE;
        tick();
        target_valid_i = 1'b0;
        checks++; if (instr_addr_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_align got a=%h exp=fffffffc", instr_addr_o); end
        complete_fetch(32'h4444_4444);
        retire_i = 1'b1;
        tick();
        retire_i = 1'b0;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin failures++; $display("FAIL wrap_inc got r=%b a=%h exp 1/00000000", instr_req_o, instr_addr_o); end
        complete_fetch(32'h5555_5555);
        retire_i = 1'b1;
        tick();
        retire_i = 1'b0;
    endtask

    task automatic test_mid_reset();
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0;
        checks++; if (pc_o !== 32'h4) begin failures++; $display("FAIL pre_reset_pc got=%h exp=00000004", pc_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (instr_req_o !== 1'b0 || inst_valid_o !== 1'b0 || pc_o !== 32'h0 || instr_o !== 32'h0000_0013) begin failures++; $display("FAIL async_reset got r=%b v=%b pc=%h i=%h", instr_req_o, inst_valid_o, pc_o, instr_o); end
        fetch_en_i = 1'b0;
        tick();
        rst_n = 1'b1; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h6666_6666;
        tick();
        instr_rvalid_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b0 || instr_req_o !== 1'b0 || instr_o !== 32'h0000_0013) begin failures++; $display("FAIL late_rvalid got v=%b r=%b i=%h", inst_valid_o, instr_req_o, instr_o); end
        fetch_en_i = 1'b1;
        tick();
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin failures++; $display("FAIL reboot_req got r=%b a=%h exp 1/00000000", instr_req_o, instr_addr_o); end
        complete_fetch(32'h7777_7777);
        checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'h7777_7777) begin failures++; $display("FAIL reboot_hold got v=%b pc=%h i=%h", inst_valid_o, pc_o, instr_o); end
    endtask

    initial begin
        test_reset();
        test_retire_stream();
        test_retire_and_target();
        test_redirect_wait();
        test_gnt_stall();
        test_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
